// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage of the MIPS pipeline.
// Fixed latency is modelled by a busy counter; results commit to HI/LO on the final busy edge.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  MDU_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_result
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        opKind_q, opKind_d;
  logic [31:0]       opA_q, opA_d;
  logic [31:0]       opB_q, opB_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic              acc;
  logic              isMul;
  logic              isSigned;
  logic [63:0]       product;
  logic [31:0]       dvdMag, dvsMag, dvsSafe;
  logic [31:0]       quoMag, remMag;
  logic [31:0]       quotient, remainder;

  assign acc      = start & ~flush & (state_q == IDLE);
  assign isMul    = (opKind_q == OP_MULT) || (opKind_q == OP_MULTU);
  assign isSigned = (opKind_q == OP_MULT) || (opKind_q == OP_DIV);

  // Sign-extending for MULT makes the low 64 bits of an unsigned multiply the signed product.
  always_comb begin
    if (isSigned) begin
      product = {{32{opA_q[31]}}, opA_q} * {{32{opB_q[31]}}, opB_q};
    end else begin
      product = {32'd0, opA_q} * {32'd0, opB_q};
    end
  end

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000 rem 0.
  always_comb begin
    dvdMag    = (isSigned && opA_q[31]) ? (32'd0 - opA_q) : opA_q;
    dvsMag    = (isSigned && opB_q[31]) ? (32'd0 - opB_q) : opB_q;
    dvsSafe   = (dvsMag == 32'd0) ? 32'd1 : dvsMag;
    quoMag    = dvdMag / dvsSafe;
    remMag    = dvdMag % dvsSafe;
    quotient  = (isSigned && (opA_q[31] ^ opB_q[31])) ? (32'd0 - quoMag) : quoMag;
    remainder = (isSigned && opA_q[31]) ? (32'd0 - remMag) : remMag;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opKind_d = opKind_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          case (MDU_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              opKind_d = MDU_op;
              opA_d    = A;
              opB_d    = B;
              cnt_d    = ((MDU_op == OP_MULT) || (MDU_op == OP_MULTU)) ? MULT_CNT : DIV_CNT;
              state_d  = BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          if (isMul) begin
            hi_d = product[63:32];
            lo_d = product[31:0];
          end else if (opB_q != 32'd0) begin
            hi_d = remainder;
            lo_d = quotient;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opKind_q <= 4'd0;
      opA_q    <= 32'd0;
      opB_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opKind_q <= opKind_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    case (MDU_op)
      OP_MFHI: MDU_result = hi_q;
      OP_MFLO: MDU_result = lo_q;
      default: MDU_result = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed table-driven bench for mdu_ctrl plus hand sequences for mid-op requests,
// flush, and asynchronous reset during an operation.
module tb_mdu_ctrl;

  logic        clk;
  logic        resetN;
  logic        start;
  logic [3:0]  mduOp;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        flush;
  logic        busy;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic [31:0] mduResult;

  int passCount;
  int totalCount;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expCycles;
  } vec_t;

  vec_t vecs[15];

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk),
    .reset_n(resetN),
    .start(start),
    .MDU_op(mduOp),
    .A(opA),
    .B(opB),
    .flush(flush),
    .busy(busy),
    .HI(hiOut),
    .LO(loOut),
    .MDU_result(mduResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Presents one request for a single cycle; returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    mduOp = op;
    opA   = a;
    opB   = b;
    @(negedge clk);
    start = 1'b0;
    mduOp = 4'd0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy && cycles < 64) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int m;
    passCount  = 0;
    totalCount = 0;
    resetN = 1'b0;
    start  = 1'b0;
    mduOp  = 4'd0;
    opA    = 32'd0;
    opB    = 32'd0;
    flush  = 1'b0;

    vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{4'd4, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[6]  = '{4'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vecs[7]  = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8]  = '{4'd3, 32'h00000005, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[9]  = '{4'd2, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 5};
    vecs[10] = '{4'd7, 32'h12345678, 32'h00000000, 32'h12345678, 32'h00000000, 0};
    vecs[11] = '{4'd8, 32'h9ABCDEF0, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 0};
    vecs[12] = '{4'd5, 32'h0000FFFF, 32'h00000001, 32'h12345678, 32'h9ABCDEF0, 0};
    vecs[13] = '{4'd12, 32'h00000001, 32'h00000001, 32'h12345678, 32'h9ABCDEF0, 0};
    vecs[14] = '{4'd0, 32'h00000003, 32'h00000003, 32'h12345678, 32'h9ABCDEF0, 0};

    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset HI", hiOut, 32'd0);
    checkOutput("reset LO", loOut, 32'd0);
    resetN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitIdle(n);
      checkOutput($sformatf("vec%0d busy cycles", i), 32'(n), 32'(vecs[i].expCycles));
      checkOutput($sformatf("vec%0d HI", i), hiOut, vecs[i].expHi);
      checkOutput($sformatf("vec%0d LO", i), loOut, vecs[i].expLo);
    end

    mduOp = 4'd5;
    #1 checkOutput("MFHI result", mduResult, 32'h12345678);
    mduOp = 4'd6;
    #1 checkOutput("MFLO result", mduResult, 32'h9ABCDEF0);
    mduOp = 4'd0;
    #1 checkOutput("NONE result", mduResult, 32'd0);
    mduOp = 4'd9;
    #1 checkOutput("undef result", mduResult, 32'd0);
    mduOp = 4'd0;
    @(negedge clk);

    // MULTU with operand changes and an MTHI request while busy
    applyStimulus(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n = busy ? 1 : 0;
    opA   = 32'h00000005;
    opB   = 32'h00000005;
    start = 1'b1;
    mduOp = 4'd7;
    opA   = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    mduOp = 4'd0;
    waitIdle(m);
    checkOutput("midop busy cycles", 32'(n + m), 32'd5);
    checkOutput("midop HI", hiOut, 32'hFFFFFFFE);
    checkOutput("midop LO", loOut, 32'h00000001);

    // Flushed requests must leave everything untouched
    flush = 1'b1;
    applyStimulus(4'd1, 32'h00000010, 32'h00000010);
    applyStimulus(4'd8, 32'h00000000, 32'h00000000);
    flush = 1'b0;
    checkOutput("flush busy", {31'd0, busy}, 32'd0);
    checkOutput("flush HI", hiOut, 32'hFFFFFFFE);
    checkOutput("flush LO", loOut, 32'h00000001);

    // DIV 100 / -7 with flush pulsed in its third busy cycle
    applyStimulus(4'd3, 32'd100, 32'hFFFFFFF9);
    n = 0;
    for (int k = 0; k < 2; k++) begin
      if (busy) n++;
      @(negedge clk);
    end
    if (busy) n++;
    flush = 1'b1;
    start = 1'b1;
    mduOp = 4'd8;
    opA   = 32'h00000000;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    mduOp = 4'd0;
    waitIdle(m);
    checkOutput("flushdiv busy cycles", 32'(n + m), 32'd10);
    checkOutput("flushdiv HI", hiOut, 32'h00000002);
    checkOutput("flushdiv LO", loOut, 32'hFFFFFFF2);

    // Asynchronous reset in the middle of a DIV
    applyStimulus(4'd3, 32'd9, 32'd2);
    repeat (3) @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    checkOutput("async rst busy", {31'd0, busy}, 32'd0);
    checkOutput("async rst HI", hiOut, 32'd0);
    checkOutput("async rst LO", loOut, 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    applyStimulus(4'd1, 32'd3, 32'd4);
    waitIdle(n);
    checkOutput("post rst busy cycles", 32'(n), 32'd5);
    checkOutput("post rst HI", hiOut, 32'd0);
    checkOutput("post rst LO", loOut, 32'h0000000C);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS CPU.
- Sits in the E stage beside the single-cycle ALU.
- Accepts mult/multu/div/divu, models their fixed latency with a busy counter, and commits results to HI/LO.
- Serves mfhi/mflo/mthi/mtlo.
- Exposes `busy` so hazard logic stalls dependent MDU instructions.
- Qualifies every state-changing request with the exception flush so a cancelled instruction never changes HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  E-stage instruction is an MDU op (mult/multu/div/divu/mthi/mtlo)
- MDU_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; others treated as NONE
- A  input  32  rs operand
- B  input  32  rt operand
- flush  input  1  exception/interrupt taken this cycle; cancels the current E-stage request
- busy  output  1  multi-cycle operation in flight
- HI  output  32  HI register
- LO  output  32  LO register
- MDU_result  output  32  combinational: HI if MDU_op=MFHI, LO if MDU_op=MFLO, else 0

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-operation): state IDLE, counter 0, busy 0, HI 0, LO 0. Any in-flight operation is discarded.
- Accept condition: `acc = start & ~flush & (state==IDLE)`. Requests while BUSY are ignored; hazard logic guarantees none arrive. Requests with flush=1 have no effect.
- MULT/MULTU/DIV/DIVU accepted at edge t0:
  - Latch A, B and op.
  - Counter = N (MULT_CYCLES or DIV_CYCLES); state goes to BUSY.
  - busy is registered and is 1 for exactly N cycles, t0+1 .. t0+N.
  - At the edge ending cycle t0+N: HI/LO written, counter reaches 0, state returns to IDLE, busy returns to 0.
  - A new op may be accepted in cycle t0+N+1.
- MULT: {HI,LO} = 64-bit signed product. MULTU: 64-bit unsigned product.
- DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient in LO, remainder in HI.
- Divide by zero (B=0 for DIV/DIVU): the full busy sequence still runs; HI and LO are left unchanged.
- MTHI/MTLO accepted: HI<=A (or LO<=A) at the same edge; busy stays 0; single cycle.
- MFHI/MFLO: no state change; MDU_result is purely combinational from the current HI/LO. If read while busy it returns old values; the stall prevents this in the pipeline.
- flush while BUSY does not abort: the in-flight op belongs to an older instruction and completes normally.
- start with MDU_op NONE/MFHI/MFLO or an undefined code causes no state change.
- Operand inputs are don't-care after the accept edge; results depend only on the latched values.
- HI/LO are written only at the completion edge or by an MT* accept edge; never at any other time.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE(-2), B=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy 0 on the 6th cycle.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001. Mid-operation, change A/B and assert start+MTHI -> both ignored.
- DIV A=0xFFFFFFF9(-7), B=2 -> 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU A=7, B=0 -> 10 busy cycles; HI/LO unchanged.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 on consecutive cycles -> busy stays 0; MFHI gives 0x12345678 and MFLO gives 0x9ABCDEF0 combinationally.
- start+MULT with flush=1 -> busy stays 0, HI/LO unchanged. DIV accepted, flush pulsed during cycle 3 -> DIV still completes with correct HI/LO after 10 cycles.
- DIV in flight, reset_n pulled low at cycle 4 -> busy, HI and LO go to 0 immediately, before any clock edge; after release, idle and ready to accept.
